// File: rtl/raytrace_pkg.sv
// Types and frame constants shared by the ray-tracing front end.
// Covers the pixel issuer, its tag FIFO and the eye-to-pixel stage.
package raytrace_pkg;

  localparam int unsigned FRAME_WIDTH  = 512;
  localparam int unsigned FRAME_HEIGHT = 384;

  localparam int unsigned X_W     = 11;
  localparam int unsigned Y_W     = 10;
  localparam int unsigned COORD_W = X_W + Y_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } issuer_state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;

  function automatic coord_t pack_coord(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    coord_t c;
    c.x = x;
    c.y = y;
    return c;
  endfunction

endpackage

// File: rtl/coord_tag_fifo.sv
// Synchronous FIFO of pixel coordinates with a combinational head read.
// A push while full and a pop while empty are both dropped without changing state.
module coord_tag_fifo
  import raytrace_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [COORD_W-1:0] data_i,
  input  logic               pop_i,
  output logic [COORD_W-1:0] head_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [COORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pixel_ray_issuer.sv
// Raster-order pixel issuer feeding the ray generator under downstream credits.
// Holds issued coordinates in a tag FIFO so they line up with the returning ray directions.
module pixel_ray_issuer
  import raytrace_pkg::*;
#(
  parameter int unsigned WIDTH        = FRAME_WIDTH,
  parameter int unsigned HEIGHT       = FRAME_HEIGHT,
  parameter int unsigned MAX_INFLIGHT = 128
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           start_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           valid_out,
  input  logic           dir_valid_in,
  input  logic           credit_return_in,
  output logic [X_W-1:0] tag_x_out,
  output logic [Y_W-1:0] tag_y_out,
  output logic           busy_out,
  output logic           frame_done_out,
  output logic           tag_err_out
);

  localparam int unsigned       CRED_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_INFLIGHT);
  localparam logic [X_W-1:0]    X_LAST   = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(HEIGHT - 1);

  issuer_state_e      state_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [CRED_W-1:0]  credit_q, credit_d;
  coord_t             out_q;
  logic               valid_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               tag_err_q;

  logic [COORD_W-1:0] fifo_head;
  logic [CRED_W-1:0]  fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  coord_t             head_c;

  logic               issue_c;
  logic               ret_ok_c;
  logic               last_pix_c;
  logic               drained_c;
  logic               tag_err_set_c;

  // fifo_full never gates in practice: credits already bound occupancy.
  assign issue_c       = (state_q == ST_RUN) && (credit_q != '0) && !fifo_full;
  assign ret_ok_c      = credit_return_in && (credit_q != CRED_MAX);
  assign last_pix_c    = (x_q == X_LAST) && (y_q == Y_LAST);
  assign drained_c     = (credit_q == CRED_MAX) && (fifo_count == '0);
  assign tag_err_set_c = (dir_valid_in && fifo_empty) ||
                         (credit_return_in && (credit_q == CRED_MAX));

  always_comb begin
    credit_d = credit_q;
    case ({issue_c, ret_ok_c})
      2'b10:   credit_d = credit_q - CRED_W'(1);
      2'b01:   credit_d = credit_q + CRED_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      credit_q     <= CRED_MAX;
      out_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tag_err_q    <= 1'b0;
    end else begin
      valid_q      <= issue_c;
      frame_done_q <= 1'b0;
      credit_q     <= credit_d;
      if (tag_err_set_c) begin
        tag_err_q <= 1'b1;
      end
      // Counters advance x-inner; y past the last row is never used.
      if (issue_c) begin
        out_q <= pack_coord(x_q, y_q);
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + Y_W'(1);
        end else begin
          x_q <= x_q + X_W'(1);
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        ST_RUN: begin
          if (issue_c && last_pix_c) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained_c) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  coord_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (issue_c),
    .data_i  (COORD_W'(pack_coord(x_q, y_q))),
    .pop_i   (dir_valid_in),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_c         = coord_t'(fifo_head);
  assign tag_x_out      = head_c.x;
  assign tag_y_out      = head_c.y;
  assign x_out          = out_q.x;
  assign y_out          = out_q.y;
  assign valid_out      = valid_q;
  assign busy_out       = busy_q;
  assign frame_done_out = frame_done_q;
  assign tag_err_out    = tag_err_q;

endmodule
